regfile_bel_mp: RTL and testbench
=================================

Name: regfile_bel_mp

Overview:
- Parametrised multi-port register-file BEL for the RegFile tile column of the eFPGA fabric; successor to the fixed 2-read/1-write tile register file.
- Data width, depth and read-port count are parameters; per-port read mode (registered or combinational) and write-through bypass are set by configuration bits.
- Adds a post-reset hardware clear sequencer, so the array holds known zeros before user logic runs.
- Sits inside the tile next to the switch matrix, which drives its inputs and routes its outputs; clocked by UserCLK.

Parameters:
- DATA_WIDTH, 4, bits per entry.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of independent read ports (1..4).
- NoConfigBits, 2*NUM_RD, config bits: per port {bypass_en, reg_mode}.

Ports:
- UserCLK  input  1  fabric user clock; only clock.
- UserRSTn  input  1  synchronous active-low reset.
- W_en  input  1  write enable, active high.
- W_ADR  input  ADDR_WIDTH  write address.
- D  input  DATA_WIDTH  write data.
- R_ADR  input  NUM_RD*ADDR_WIDTH  read addresses; port p is slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- R_D  output  NUM_RD*DATA_WIDTH  read data, same slicing.
- busy  output  1  high while the clear sequencer runs.
- ConfigBits  input  NoConfigBits  static config from the tile config latches; bit 2p = reg_mode[p], bit 2p+1 = bypass_en[p].

Interface decision: one clock, UserCLK; reset UserRSTn is synchronous and active-low.

Behaviour:
- All state updates on the rising edge of UserCLK. UserRSTn is sampled only at the edge.
- Reset (UserRSTn=0 at an edge):
  - FSM goes to CLEAR; clr_addr = 0; busy = 1.
  - All registered read outputs = 0.
  - Array contents are not reset directly; the sequencer zeroes them.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr. When clr_addr = DEPTH-1 is written, go to READY next cycle.
  - READY: busy = 0; normal operation.
  - The clear takes exactly DEPTH cycles after reset deassertion.
- Reset mid-clear: clr_addr restarts at 0; a full DEPTH-cycle clear follows.
- During CLEAR:
  - W_en is ignored; user writes are dropped, not queued.
  - Every R_D slice reads 0, whatever mode the port is in.
- Write (READY): if W_en=1 at an edge, mem[W_ADR] <= D. Visible to plain reads from the next cycle.
- Read port p, reg_mode[p]=0 (combinational): R_D[p] = mem[R_ADR[p]], zero latency.
- Read port p, reg_mode[p]=1 (registered): R_D[p] is registered from mem[R_ADR[p]]; latency 1 cycle.
- Bypass, bypass_en[p]=1, with W_en=1 and W_ADR == R_ADR[p] in the same cycle:
  - Combinational port: R_D[p] = D in that cycle.
  - Registered port: register captures D.
- bypass_en[p]=0: the port returns the old contents on a same-cycle collision (read-before-write).
- Several read ports on the same address are independent; no arbitration. Any port/address combination is legal.
- Address range: the full 2**ADDR_WIDTH range is valid; no out-of-range case and no wrap logic beyond natural width.
- ConfigBits are static after configuration. Changing them during operation gives undefined R_D for one cycle only; no state corruption.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum {CLEAR, READY}.
  - ConfigBits field offsets: CFG_REG_MODE = 0, CFG_BYPASS = 1, CFG_STRIDE = 2.
  - Localparam function computing DEPTH.
- One sub-module, regfile_rd_port: address/bypass mux plus optional output register. Instantiated NUM_RD times in a generate loop.
- Array and clear FSM live in the top module.

Test Plan:
- Reset hold 3 cycles, then release (ADDR_WIDTH=5) -> busy=1 for exactly 32 cycles then 0. A readback of all 32 addresses returns 0, including addresses pre-written to 0xF before reset.
- Assert reset at clear cycle 10 for 1 cycle -> busy stays high another full 32 cycles after release. mem[31] reads 0 afterwards.
- W_en=1 during CLEAR, W_ADR=3, D=0xA -> after busy falls, mem[3] reads 0.
- READY, port0 combinational with bypass, port1 registered with no bypass, mem[7]=0x2. Write D=0x9 to 7 while both ports read 7 -> port0 shows 0x9 the same cycle; port1 shows 0x2 next cycle, then 0x9 the cycle after.
- Port1 registered with bypass, same collision -> port1 shows 0x9 one cycle later.
- NUM_RD=4, all ports on address 5 holding 0x6 -> all four slices equal 0x6. Parameter sweep DATA_WIDTH=8, ADDR_WIDTH=3 passes the clear-length check (8 cycles).

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register-file BEL.
//   - rf_state_e : clear sequencer states
//   - CFG_*      : field offsets inside each read port's ConfigBits group
//   - rf_depth() : entry count for a given address width
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // ConfigBits layout, per read port p: bit p*CFG_STRIDE+CFG_REG_MODE,
    // bit p*CFG_STRIDE+CFG_BYPASS.
    localparam int CFG_REG_MODE = 0;
    localparam int CFG_BYPASS   = 1;
    localparam int CFG_STRIDE   = 2;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_bel_mp_if.sv
// regfile_bel_mp_if: data-path bundle between the switch matrix and the BEL.
//   W_en/W_ADR/D : write port
//   R_ADR        : packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   R_D          : packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   busy         : clear sequencer running
// master = switch-matrix side, slave = register file.
interface regfile_bel_mp_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         W_en;
    logic [ADDR_WIDTH-1:0]        W_ADR;
    logic [DATA_WIDTH-1:0]        D;
    logic [NUM_RD*ADDR_WIDTH-1:0] R_ADR;
    logic [NUM_RD*DATA_WIDTH-1:0] R_D;
    logic                         busy;

    modport master (
        output W_en, W_ADR, D, R_ADR,
        input  R_D, busy
    );

    modport slave (
        input  W_en, W_ADR, D, R_ADR,
        output R_D, busy
    );
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port of the register file.
//   clk/rst_n            : user clock, synchronous active-low reset
//   clr                  : clear sequencer active; forces output and register to 0
//   reg_mode / bypass_en : static port configuration
//   rd_addr / rd_word    : read address and the array word at that address
//   wr_en/wr_addr/wr_data: effective write (already blocked during clear)
//   rd_data              : port output
module regfile_rd_port #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  reg_mode,
    input  logic                  bypass_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic                  hit;
    logic [DATA_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] q;

    // Same-cycle write to the address being read: forward the write data
    // when bypass is enabled, otherwise the old array word is returned.
    assign hit = bypass_en & wr_en & (wr_addr == rd_addr);
    assign sel = hit ? wr_data : rd_word;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) q <= '0;
        else               q <= sel;
    end

    assign rd_data = clr ? '0 : (reg_mode ? q : sel);
endmodule

// File: rtl/regfile_bel_mp.sv
// regfile_bel_mp: parametrised multi-port register-file BEL.
//   UserCLK    : fabric user clock
//   UserRSTn   : synchronous active-low reset; restarts the clear sequencer
//   ConfigBits : per read port {bypass_en, reg_mode}
//   bus        : write port, read ports and busy (regfile_bel_mp_if.slave)
// After reset the sequencer zeroes one entry per cycle (DEPTH cycles);
// user writes are dropped and all read ports return 0 while it runs.
module regfile_bel_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD       = 2,
    parameter int NoConfigBits = 2 * NUM_RD
) (
    input  logic                    UserCLK,
    input  logic                    UserRSTn,
    input  logic [NoConfigBits-1:0] ConfigBits,
    regfile_bel_mp_if.slave         bus
);
    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    rf_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clearing;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_word;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

    // Clear sequencer
    always_ff @(posedge UserCLK) begin
        if (!UserRSTn) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clearing ? clr_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        clearing  = 1'b0;
        case (state)
            CLEAR: begin
                clearing = 1'b1;
                // Last entry is written this cycle.
                if (&clr_addr) state_nxt = READY;
            end
            READY: ;
            default: state_nxt = CLEAR;
        endcase
    end

    assign bus.busy = clearing;
    assign wr_en    = bus.W_en & ~clearing;

    // Array: no reset of its own, the sequencer owns initialisation.
    always_ff @(posedge UserCLK) begin
        if (UserRSTn) begin
            if (clearing)   mem[clr_addr]  <= '0;
            else if (wr_en) mem[bus.W_ADR] <= bus.D;
        end
    end

    assign rd_addr = bus.R_ADR;
    assign bus.R_D = rd_data;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_word[p] = mem[rd_addr[p]];

        regfile_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_rd (
            .clk       (UserCLK),
            .rst_n     (UserRSTn),
            .clr       (clearing),
            .reg_mode  (ConfigBits[p*CFG_STRIDE + CFG_REG_MODE]),
            .bypass_en (ConfigBits[p*CFG_STRIDE + CFG_BYPASS]),
            .rd_addr   (rd_addr[p]),
            .rd_word   (rd_word[p]),
            .wr_en     (wr_en),
            .wr_addr   (bus.W_ADR),
            .wr_data   (bus.D),
            .rd_data   (rd_data[p])
        );
    end
endmodule

// File: tb/tb_regfile_bel_mp.sv
// tb_regfile_bel_mp: directed checks of the clear sequencer, write drop
// during clear, read modes, bypass, and two parameter variants.
module tb_regfile_bel_mp;
    logic UserCLK = 1'b0;
    logic UserRSTn;
    logic [3:0] cfg_a;
    logic [7:0] cfg_b;
    logic [1:0] cfg_c;

    always #5 UserCLK = ~UserCLK;

    regfile_bel_mp_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .NUM_RD(2)) bus_a ();
    regfile_bel_mp_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .NUM_RD(4)) bus_b ();
    regfile_bel_mp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(1)) bus_c ();

    regfile_bel_mp #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .NUM_RD(2)) u_dut_a (
        .UserCLK(UserCLK), .UserRSTn(UserRSTn), .ConfigBits(cfg_a), .bus(bus_a));
    regfile_bel_mp #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .NUM_RD(4)) u_dut_b (
        .UserCLK(UserCLK), .UserRSTn(UserRSTn), .ConfigBits(cfg_b), .bus(bus_b));
    regfile_bel_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(1)) u_dut_c (
        .UserCLK(UserCLK), .UserRSTn(UserRSTn), .ConfigBits(cfg_c), .bus(bus_c));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr_a(input logic [4:0] a, input logic [3:0] d);
        bus_a.W_en  = 1'b1;
        bus_a.W_ADR = a;
        bus_a.D     = d;
        @(negedge UserCLK);
        bus_a.W_en  = 1'b0;
    endtask

    // Called right at reset release; counts cycles each DUT reports busy.
    task automatic count_busy(output int ca, output int cb, output int cc);
        ca = 0; cb = 0; cc = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus_a.busy) ca++;
            if (bus_b.busy) cb++;
            if (bus_c.busy) cc++;
            if (!bus_a.busy && !bus_b.busy && !bus_c.busy) break;
            @(negedge UserCLK);
        end
    endtask

    task automatic reset_release(input int n);
        UserRSTn = 1'b0;
        repeat (n) @(negedge UserCLK);
        UserRSTn = 1'b1;
    endtask

    initial begin
        int ca, cb, cc;
        UserRSTn    = 1'b0;
        cfg_a       = 4'b0000;
        cfg_b       = 8'h00;
        cfg_c       = 2'b00;
        bus_a.W_en  = 1'b0; bus_a.W_ADR = '0; bus_a.D = '0; bus_a.R_ADR = '0;
        bus_b.W_en  = 1'b0; bus_b.W_ADR = '0; bus_b.D = '0; bus_b.R_ADR = '0;
        bus_c.W_en  = 1'b0; bus_c.W_ADR = '0; bus_c.D = '0; bus_c.R_ADR = '0;

        // Reset state
        @(negedge UserCLK);
        chk("rst_busy", 32'(bus_a.busy), 32'd1);
        chk("rst_rd", 32'(bus_a.R_D), 32'h0);
        repeat (2) @(negedge UserCLK);
        UserRSTn = 1'b1;
        count_busy(ca, cb, cc);
        chk("init_clear_len_a", ca, 32'd32);

        // Fill with 0xF, then reset and confirm the sequencer wipes it
        for (int a = 0; a < 32; a++) wr_a(5'(a), 4'hF);
        bus_a.R_ADR = {5'd0, 5'd12};
        #1 chk("prefill", 32'(bus_a.R_D[3:0]), 32'hF);
        @(negedge UserCLK);
        reset_release(3);
        count_busy(ca, cb, cc);
        chk("clear_len_a", ca, 32'd32);
        chk("clear_len_b", cb, 32'd32);
        chk("clear_len_c", cc, 32'd8);
        for (int a = 0; a < 32; a++) begin
            bus_a.R_ADR = {5'(a), 5'(a)};
            #1 chk($sformatf("readback_%0d", a), 32'(bus_a.R_D), 32'h0);
        end
        @(negedge UserCLK);

        // Reset mid-clear, user writes dropped during clear
        wr_a(5'd31, 4'hF);
        bus_a.R_ADR = {5'd31, 5'd31};
        #1 chk("pre_mid_31", 32'(bus_a.R_D[3:0]), 32'hF);
        @(negedge UserCLK);
        cfg_a = 4'b0100;
        reset_release(1);
        repeat (10) @(negedge UserCLK);
        chk("clr_rd_zero", 32'(bus_a.R_D), 32'h0);
        UserRSTn = 1'b0;
        @(negedge UserCLK);
        UserRSTn    = 1'b1;
        bus_a.W_en  = 1'b1;
        bus_a.W_ADR = 5'd3;
        bus_a.D     = 4'hA;
        count_busy(ca, cb, cc);
        bus_a.W_en  = 1'b0;
        chk("restart_len", ca, 32'd32);
        cfg_a = 4'b0000;
        bus_a.R_ADR = {5'd3, 5'd31};
        #1 chk("mid_mem31", 32'(bus_a.R_D[3:0]), 32'h0);
        chk("wr_dropped", 32'(bus_a.R_D[7:4]), 32'h0);
        @(negedge UserCLK);

        // port0 comb+bypass, port1 registered no bypass
        cfg_a = 4'b0110;
        wr_a(5'd7, 4'h2);
        bus_a.R_ADR = {5'd7, 5'd7};
        bus_a.W_en  = 1'b1; bus_a.W_ADR = 5'd7; bus_a.D = 4'h9;
        #1 chk("byp_comb", 32'(bus_a.R_D[3:0]), 32'h9);
        @(negedge UserCLK);
        bus_a.W_en = 1'b0;
        #1 chk("nobyp_reg_old", 32'(bus_a.R_D[7:4]), 32'h2);
        chk("comb_after_wr", 32'(bus_a.R_D[3:0]), 32'h9);
        @(negedge UserCLK);
        #1 chk("reg_new", 32'(bus_a.R_D[7:4]), 32'h9);

        // port0 comb no bypass, port1 registered + bypass
        @(negedge UserCLK);
        cfg_a = 4'b1100;
        wr_a(5'd7, 4'h2);
        bus_a.W_en = 1'b1; bus_a.W_ADR = 5'd7; bus_a.D = 4'h9;
        #1 chk("nobyp_comb_old", 32'(bus_a.R_D[3:0]), 32'h2);
        @(negedge UserCLK);
        bus_a.W_en = 1'b0;
        #1 chk("byp_reg", 32'(bus_a.R_D[7:4]), 32'h9);

        // Four ports on one address
        @(negedge UserCLK);
        bus_b.W_en = 1'b1; bus_b.W_ADR = 5'd5; bus_b.D = 4'h6;
        bus_b.R_ADR = {4{5'd5}};
        @(negedge UserCLK);
        bus_b.W_en = 1'b0;
        #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("four_port_%0d", p), 32'(bus_b.R_D[p*4 +: 4]), 32'h6);

        // 8-bit / 8-entry variant, registered read
        @(negedge UserCLK);
        cfg_c = 2'b01;
        bus_c.W_en = 1'b1; bus_c.W_ADR = 3'd7; bus_c.D = 8'hA5;
        bus_c.R_ADR = 3'd7;
        @(negedge UserCLK);
        bus_c.W_en = 1'b0;
        @(negedge UserCLK);
        #1 chk("c_reg_read", 32'(bus_c.R_D), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
